// File: rtl/hazard_pkg.sv
// Shared types and sizing for the register hazard scoreboard.
package hazard_pkg;
    localparam int NREG            = 32;
    localparam int REG_IDX_W       = 5;
    localparam int LATENCY_DEFAULT = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/scoreboard_entry.sv
// One register's busy timer: loads LATENCY when a producer issues, then
// counts down to zero; nonzero means the register is still pending.
module scoreboard_entry #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    output logic o_pending
);
    logic [CNT_W-1:0] cnt_r;

    // Down-counter; a new producer's load takes priority over the decrement.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (i_load) begin
            cnt_r <= CNT_W'(LATENCY);
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_pending = (cnt_r != {CNT_W{1'b0}});
endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for the ID stage: stalls readers of pending registers.
// Optional stall-cycle statistics counter enabled by HAZARD_STATS_EN.
module hazard_scoreboard #(
    parameter int LATENCY = hazard_pkg::LATENCY_DEFAULT,
    parameter int NREG    = hazard_pkg::NREG
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_id_valid,
    input  logic [hazard_pkg::REG_IDX_W-1:0] i_rs1_addr,
    input  logic [hazard_pkg::REG_IDX_W-1:0] i_rs2_addr,
    input  logic                            i_rs1_used,
    input  logic                            i_rs2_used,
    input  logic [hazard_pkg::REG_IDX_W-1:0] i_rd_addr,
    input  logic                            i_rd_wren,
    input  logic                            i_br_taken,
    output logic                            o_stall,
    output logic                            o_pc_en,
    output logic                            o_ifid_en,
    output logic                            o_idex_bubble,
    output logic                            o_issue,
    output logic [NREG-1:0]                 o_busy_mask
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                     o_stall_cycles
`endif
);
    import hazard_pkg::*;

    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [NREG-1:0] pend_s;
    logic [NREG-1:0] load_s;
    logic            rs1_hit_s;
    logic            rs2_hit_s;
    logic            hazard_s;
    logic            issue_s;
    logic            stall_s;

    assign pend_s[0] = 1'b0;
    assign load_s[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        assign load_s[r] = issue_s & i_rd_wren & (i_rd_addr == reg_idx_t'(r));

        scoreboard_entry #(
            .LATENCY (LATENCY),
            .CNT_W   (CNT_W)
        ) u_entry (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_load    (load_s[r]),
            .o_pending (pend_s[r])
        );
    end

    // Source lookups; x0 and unused sources never hit.
    always_comb begin
        rs1_hit_s = 1'b0;
        rs2_hit_s = 1'b0;
        if (i_rs1_used && (i_rs1_addr != {REG_IDX_W{1'b0}}) && (int'(i_rs1_addr) < NREG)) begin
            rs1_hit_s = pend_s[i_rs1_addr];
        end else begin
            rs1_hit_s = 1'b0;
        end
        if (i_rs2_used && (i_rs2_addr != {REG_IDX_W{1'b0}}) && (int'(i_rs2_addr) < NREG)) begin
            rs2_hit_s = pend_s[i_rs2_addr];
        end else begin
            rs2_hit_s = 1'b0;
        end
    end

    // Control outputs; reset forces the quiescent values, a redirect overrides the stall.
    always_comb begin
        hazard_s = i_id_valid & (rs1_hit_s | rs2_hit_s);
        if (i_reset) begin
            issue_s = 1'b0;
            stall_s = 1'b0;
        end else begin
            issue_s = i_id_valid & ~hazard_s & ~i_br_taken;
            stall_s = hazard_s & ~i_br_taken;
        end
    end

    assign o_issue       = issue_s;
    assign o_stall       = stall_s;
    assign o_idex_bubble = ~issue_s;
    assign o_pc_en       = ~i_reset & ~stall_s;
    assign o_ifid_en     = ~i_reset & ~stall_s;
    assign o_busy_mask   = i_reset ? {NREG{1'b0}} : pend_s;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_r;

    // Free-running stall counter, wraps naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_s) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign o_stall_cycles = stall_cycles_r;
`endif
endmodule
